lenet_conv_layer: RTL
=====================

Name: lenet_conv_layer

Overview:
Parametrised multi-channel 2-D convolution engine. It replaces the fixed single-channel CONV1 stage and is reusable for CONV1, CONV2 and CONV3 of the LeNet pipeline.
- Image tiles and kernels are loaded into internal RAM through write ports.
- A start pulse computes every output pixel with one MAC per cycle.
- Results stream out over a valid/ready interface to the following MAX stage.
- Adds input/output channels, zero padding, arbitrary stride and backpressure.

Parameters:
IMAGE_PIXEL_WIDTH, 8, unsigned input pixel width
KERNEL_PIXEL_WIDTH, 5, signed two's-complement weight width
IMAGE_WIDTH, 32, square input side length
KERNEL_SIZE, 5, square kernel side length
STRIDE, 1, step in rows and columns, >=1
PADDING, 0, zero border on every side
IN_CH, 1, input channels
OUT_CH, 6, output channels
(derived) OUT_WIDTH = (IMAGE_WIDTH+2*PADDING-KERNEL_SIZE)/STRIDE+1
(derived) ACC_W = IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH+1+$clog2(IN_CH*KERNEL_SIZE*KERNEL_SIZE)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; begins a layer pass when idle
img_wen  in  1  image RAM write enable
img_waddr  in  $clog2(IN_CH*IMAGE_WIDTH^2)  address = ch*W*W + row*W + col
img_wdata  in  IMAGE_PIXEL_WIDTH  pixel
ker_wen  in  1  kernel RAM write enable
ker_waddr  in  $clog2(OUT_CH*IN_CH*KERNEL_SIZE^2)  address = ((oc*IN_CH+ic)*K+kr)*K+kc
ker_wdata  in  KERNEL_PIXEL_WIDTH  signed weight
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  ACC_W  signed convolution sum
out_last  out  1  high with the final pixel of the pass
busy  out  1  high from the start-accept cycle until the DONE state
done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset: state=IDLE; out_valid, out_data, out_last, busy and done all 0; counters 0. RAM contents are not cleared.
- RAMs: synchronous read, 1-cycle latency.
- Writes are honoured only while busy=0; ignored while busy.
- FSM states: IDLE -> CLEAR -> MAC -> DRAIN -> OUT -> (CLEAR | DONE) -> IDLE.
  - IDLE: start=1 -> CLEAR, busy=1. Start while busy is ignored.
  - CLEAR (1 cycle): acc=0; kernel counters (ic, kr, kc)=0.
  - MAC (IN_CH*K*K cycles): issue one read pair per cycle, ic outer, kc inner.
  - DRAIN (2 cycles): the last products land in the accumulator.
  - OUT: out_valid=1, out_data=acc, held stable until out_ready.
    - On handshake, advance (oc outer, orow, ocol inner) -> CLEAR.
    - After the last pixel -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Per-pixel latency without backpressure: 1+IN_CH*K*K+2+1 cycles.
- Input coordinates: irow=orow*STRIDE+kr-PADDING, icol=ocol*STRIDE+kc-PADDING.
  - If irow or icol falls outside [0,IMAGE_WIDTH-1], the pixel is 0 (zero-extended, no RAM read).
- Arithmetic: product = $signed({1'b0,pixel})*weight. Accumulation is full-width signed ACC_W, with no saturation or overflow possible.
- out_last=1 only while out_valid for oc=OUT_CH-1, orow=ocol=OUT_WIDTH-1.
- out_ready=1 while out_valid=0 has no effect.
- Reset mid-operation: immediate return to IDLE with reset output values. A subsequent start recomputes from pixel 0.

Optional Feature:
Macro LENET_CONV_RELU_EN.
- Defined: out_data = (acc<0) ? 0 : acc, i.e. ReLU fused into the output register. Applied in the OUT state; no extra latency.
- Undefined: raw signed sum.

Decomposition:
- Package lenet_pkg holds:
  - conv FSM state enum
  - helper function for OUT_WIDTH
  - ACC_W calculation function
  - default pixel widths shared by all layer stages
- One sub-module, lenet_conv_mac: registered multiply plus accumulate with clear and enable. Instantiated once.
- The RAMs are inferred inline.

Test Plan:
- Defaults, all pixels 1, all weights 1, start -> 6*28*28=4704 outputs each 25. out_last only on the 4704th. done one cycle after the final handshake.
- IMAGE_WIDTH=4, K=3, PADDING=1, STRIDE=1, IN_CH=OUT_CH=1, all ones -> 4x4 output: corners 4, edges 6, interior 9.
- IMAGE_WIDTH=5, K=3, STRIDE=2, IN_CH=2, OUT_CH=1, ch0 pixels 2, ch1 pixels 255, weights ch0=+1, ch1=-16 -> 2x2 output, each 9*2 + 9*255*(-16) = -36702. With LENET_CONV_RELU_EN each output is 0.
- Random out_ready low for 0-5 cycles -> out_data/out_last stable while valid&&!ready; sequence identical to the no-backpressure run.
- Assert rst for 1 cycle mid-pass (after 10 outputs) -> outputs 0 and busy=0 immediately. A new start reproduces the full correct sequence from pixel 0.
- img_wen/ker_wen pulses while busy with altered data -> results unchanged. start pulses while busy -> ignored, single done.

Source files
------------

// File: rtl/lenet_pkg.sv
// lenet_pkg: shared types, default widths and size helpers for the LeNet layer stages.
package lenet_pkg;

  localparam int DEF_IMAGE_PIXEL_WIDTH  = 8;
  localparam int DEF_KERNEL_PIXEL_WIDTH = 5;

  typedef logic [15:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_DONE
  } conv_state_e;

  function automatic int out_width(input int image_width, input int kernel_size,
                                   input int stride, input int padding);
    return (image_width + 2 * padding - kernel_size) / stride + 1;
  endfunction

  // Wide enough that the sum of every product of one output pixel cannot overflow.
  function automatic int acc_width(input int pix_w, input int ker_w,
                                   input int in_ch, input int kernel_size);
    return pix_w + ker_w + 1 + $clog2(in_ch * kernel_size * kernel_size);
  endfunction

endpackage

// File: rtl/lenet_conv_mac.sv
// lenet_conv_mac: registered unsigned-pixel x signed-weight multiply feeding a clearable accumulator.
module lenet_conv_mac #(
  parameter int IMAGE_PIXEL_WIDTH  = 8,
  parameter int KERNEL_PIXEL_WIDTH = 5,
  parameter int ACC_W              = 19
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 en,
  input  logic        [IMAGE_PIXEL_WIDTH-1:0]  pixel,
  input  logic signed [KERNEL_PIXEL_WIDTH-1:0] weight,
  output logic signed [ACC_W-1:0]              acc
);

  localparam int PROD_W = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH + 1;

  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      prod_valid <= en;
      if (en) prod <= PROD_W'($signed({1'b0, pixel})) * PROD_W'(weight);
      if (clear)           acc <= '0;
      else if (prod_valid) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/lenet_conv_layer.sv
// lenet_conv_layer: multi-channel 2-D convolution, one MAC per cycle, valid/ready result stream.
// Define LENET_CONV_RELU_EN to clamp negative sums to zero on the output.
module lenet_conv_layer
  import lenet_pkg::*;
#(
  parameter int IMAGE_PIXEL_WIDTH  = DEF_IMAGE_PIXEL_WIDTH,
  parameter int KERNEL_PIXEL_WIDTH = DEF_KERNEL_PIXEL_WIDTH,
  parameter int IMAGE_WIDTH        = 32,
  parameter int KERNEL_SIZE        = 5,
  parameter int STRIDE             = 1,
  parameter int PADDING            = 0,
  parameter int IN_CH              = 1,
  parameter int OUT_CH             = 6,
  localparam int OUT_WIDTH = out_width(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING),
  localparam int ACC_W     = acc_width(IMAGE_PIXEL_WIDTH, KERNEL_PIXEL_WIDTH, IN_CH, KERNEL_SIZE),
  localparam int IA_W      = $clog2(IN_CH * IMAGE_WIDTH * IMAGE_WIDTH),
  localparam int KA_W      = $clog2(OUT_CH * IN_CH * KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 img_wen,
  input  logic        [IA_W-1:0]               img_waddr,
  input  logic        [IMAGE_PIXEL_WIDTH-1:0]  img_wdata,
  input  logic                                 ker_wen,
  input  logic        [KA_W-1:0]               ker_waddr,
  input  logic signed [KERNEL_PIXEL_WIDTH-1:0] ker_wdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ACC_W-1:0]              out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int IMG_DEPTH = IN_CH * IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int KER_DEPTH = OUT_CH * IN_CH * KERNEL_SIZE * KERNEL_SIZE;

  conv_state_e state, state_nxt;
  cnt_t        ic, kr, kc, oc, orow, ocol;
  logic        drain_cnt;
  logic        k_last, px_last;

  logic        [IMAGE_PIXEL_WIDTH-1:0]  img_ram [IMG_DEPTH];
  logic signed [KERNEL_PIXEL_WIDTH-1:0] ker_ram [KER_DEPTH];
  logic        [IMAGE_PIXEL_WIDTH-1:0]  img_rdata;
  logic signed [KERNEL_PIXEL_WIDTH-1:0] ker_rdata;
  logic        [IA_W-1:0]               img_raddr;
  logic        [KA_W-1:0]               ker_raddr;
  int                                   irow, icol;
  logic                                 pad, issue, img_ren, issue_d, pad_d;
  logic signed [ACC_W-1:0]              acc;

  assign k_last  = (ic == cnt_t'(IN_CH - 1)) && (kr == cnt_t'(KERNEL_SIZE - 1)) &&
                   (kc == cnt_t'(KERNEL_SIZE - 1));
  assign px_last = (oc == cnt_t'(OUT_CH - 1)) && (orow == cnt_t'(OUT_WIDTH - 1)) &&
                   (ocol == cnt_t'(OUT_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: state_nxt = S_MAC;
      S_MAC:   if (k_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = px_last;
        if (out_ready) state_nxt = px_last ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {ic, kr, kc, oc, orow, ocol} <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) {oc, orow, ocol} <= '0;
        S_CLEAR: begin
          {ic, kr, kc} <= '0;
          drain_cnt    <= 1'b0;
        end
        S_MAC: begin
          if (kc == cnt_t'(KERNEL_SIZE - 1)) begin
            kc <= '0;
            if (kr == cnt_t'(KERNEL_SIZE - 1)) begin
              kr <= '0;
              ic <= ic + cnt_t'(1);
            end else begin
              kr <= kr + cnt_t'(1);
            end
          end else begin
            kc <= kc + cnt_t'(1);
          end
        end
        S_DRAIN: drain_cnt <= 1'b1;
        S_OUT: begin
          if (out_ready) begin
            if (ocol == cnt_t'(OUT_WIDTH - 1)) begin
              ocol <= '0;
              if (orow == cnt_t'(OUT_WIDTH - 1)) begin
                orow <= '0;
                oc   <= oc + cnt_t'(1);
              end else begin
                orow <= orow + cnt_t'(1);
              end
            end else begin
              ocol <= ocol + cnt_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Map the kernel tap onto the (possibly padded) input plane; outside taps read as zero.
  always_comb begin
    irow      = int'(orow) * STRIDE + int'(kr) - PADDING;
    icol      = int'(ocol) * STRIDE + int'(kc) - PADDING;
    pad       = (irow < 0) || (irow >= IMAGE_WIDTH) || (icol < 0) || (icol >= IMAGE_WIDTH);
    img_raddr = IA_W'((int'(ic) * IMAGE_WIDTH + irow) * IMAGE_WIDTH + icol);
    ker_raddr = KA_W'(((int'(oc) * IN_CH + int'(ic)) * KERNEL_SIZE + int'(kr)) * KERNEL_SIZE
                      + int'(kc));
    issue     = (state == S_MAC);
    img_ren   = issue && !pad;
  end

  // NOTE: RAM contents are deliberately left out of reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (img_wen && !busy) img_ram[img_waddr] <= img_wdata;
    if (ker_wen && !busy) ker_ram[ker_waddr] <= ker_wdata;
    if (img_ren)          img_rdata <= img_ram[img_raddr];
    if (issue)            ker_rdata <= ker_ram[ker_raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_d <= 1'b0;
      pad_d   <= 1'b0;
    end else begin
      issue_d <= issue;
      pad_d   <= pad;
    end
  end

  lenet_conv_mac #(
    .IMAGE_PIXEL_WIDTH  (IMAGE_PIXEL_WIDTH),
    .KERNEL_PIXEL_WIDTH (KERNEL_PIXEL_WIDTH),
    .ACC_W              (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == S_CLEAR),
    .en     (issue_d),
    .pixel  (pad_d ? '0 : img_rdata),
    .weight (ker_rdata),
    .acc    (acc)
  );

  always_comb begin
    out_data = '0;
    if (state == S_OUT) begin
`ifdef LENET_CONV_RELU_EN
      out_data = acc[ACC_W-1] ? '0 : acc;
`else
      out_data = acc;
`endif
    end
  end

endmodule
